// File: rtl/pc_control_unit_pkg.sv
// Shared pipeline control constants: FSM encodings and parameter defaults.
package pc_control_unit_pkg;

    localparam int FLUSH_DEPTH_DEF = 2;
    localparam int CNT_W_DEF       = 16;
    localparam int FLUSH_CNT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_BUBBLE   = 2'd3
    } pcu_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_control_unit.sv
// Pipeline PC/flush controller: branch redirect, load-use bubble, memory-stall
// freeze with a one-entry pending branch, and a stall performance counter.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | out of reset, waiting one edge before running
//   RUN      | normal flow; samples branch / load-use events
//   REDIRECT | branch issued; IF/ID flush held for FLUSH_DEPTH cycles
//   BUBBLE   | load-use step-back, one cycle
module pc_control_unit
    import pc_control_unit_pkg::*;
#(
    parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IMEM_BUSY,
    input  logic             DMEM_BUSY,
    input  logic             LOAD_USE,
    input  logic             BRANCH_TAKEN,
    input  logic [31:0]      BRANCH_OFFSET,
    output logic             BUSY_WAIT,
    output logic             CON_BRANCH,
    output logic [31:0]      BRANCH_PC,
    output logic             PC_DEC,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_FLUSH,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STALL_COUNT
);

    pcu_state_e             state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [31:0]            branch_pc_q, branch_pc_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [31:0]            pend_off_q, pend_off_d;
    logic                   con_branch_q, con_branch_d;
    logic                   pc_dec_q, pc_dec_d;
    logic                   if_id_flush_q, if_id_flush_d;
    logic                   id_ex_flush_q, id_ex_flush_d;
    logic                   busy_wait;

    assign busy_wait = IMEM_BUSY | DMEM_BUSY;

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        branch_pc_d   = branch_pc_q;
        pend_vld_d    = pend_vld_q;
        pend_off_d    = pend_off_q;
        con_branch_d  = con_branch_q;
        pc_dec_d      = pc_dec_q;
        if_id_flush_d = if_id_flush_q;
        id_ex_flush_d = id_ex_flush_q;

        if (busy_wait) begin
            // Frozen: only a fresh branch in RUN is parked for later issue.
            if ((state_q == ST_RUN) && BRANCH_TAKEN && !pend_vld_q) begin
                pend_vld_d = 1'b1;
                pend_off_d = BRANCH_OFFSET;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (pend_vld_q || BRANCH_TAKEN) begin
                        state_d       = ST_REDIRECT;
                        branch_pc_d   = pend_vld_q ? pend_off_q : BRANCH_OFFSET;
                        pend_vld_d    = 1'b0;
                        con_branch_d  = 1'b1;
                        if_id_flush_d = 1'b1;
                        id_ex_flush_d = 1'b1;
                        flush_cnt_d   = FLUSH_CNT_W'(FLUSH_DEPTH - 1);
                    end else if (LOAD_USE) begin
                        state_d       = ST_BUBBLE;
                        pc_dec_d      = 1'b1;
                        id_ex_flush_d = 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    con_branch_d  = 1'b0;
                    id_ex_flush_d = 1'b0;
                    if (flush_cnt_q != '0) begin
                        flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
                    end else begin
                        if_id_flush_d = 1'b0;
                        state_d       = ST_RUN;
                    end
                end
                ST_BUBBLE: begin
                    pc_dec_d      = 1'b0;
                    id_ex_flush_d = 1'b0;
                    state_d       = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= ST_IDLE;
            flush_cnt_q   <= '0;
            branch_pc_q   <= '0;
            pend_vld_q    <= 1'b0;
            pend_off_q    <= '0;
            con_branch_q  <= 1'b0;
            pc_dec_q      <= 1'b0;
            if_id_flush_q <= 1'b0;
            id_ex_flush_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            branch_pc_q   <= branch_pc_d;
            pend_vld_q    <= pend_vld_d;
            pend_off_q    <= pend_off_d;
            con_branch_q  <= con_branch_d;
            pc_dec_q      <= pc_dec_d;
            if_id_flush_q <= if_id_flush_d;
            id_ex_flush_q <= id_ex_flush_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (CLK),
        .rst_n (RESET),
        .inc   (busy_wait | pc_dec_q),
        .count (STALL_COUNT)
    );

    assign BUSY_WAIT   = busy_wait;
    assign CON_BRANCH  = con_branch_q;
    assign BRANCH_PC   = branch_pc_q;
    assign PC_DEC      = pc_dec_q;
    assign IF_ID_FLUSH = if_id_flush_q;
    assign ID_EX_FLUSH = id_ex_flush_q;
    assign STATE       = state_q;

endmodule

// File: tb/tb_pc_control_unit.sv
// Directed bench for pc_control_unit: default instance plus a CNT_W=4 instance
// for counter saturation.
module tb_pc_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_busy, dmem_busy, load_use, branch_taken;
    logic [31:0] branch_offset;
    logic        busy_wait, con_branch, pc_dec, if_id_flush, id_ex_flush;
    logic [31:0] branch_pc;
    logic [1:0]  state;
    logic [15:0] stall_count;

    logic        imem4;
    logic        busy4, con4, pcdec4, ifid4, idex4;
    logic [31:0] bpc4;
    logic [1:0]  state4;
    logic [3:0]  stall4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pc_control_unit dut (
        .CLK           (clk),
        .RESET         (rst_n),
        .IMEM_BUSY     (imem_busy),
        .DMEM_BUSY     (dmem_busy),
        .LOAD_USE      (load_use),
        .BRANCH_TAKEN  (branch_taken),
        .BRANCH_OFFSET (branch_offset),
        .BUSY_WAIT     (busy_wait),
        .CON_BRANCH    (con_branch),
        .BRANCH_PC     (branch_pc),
        .PC_DEC        (pc_dec),
        .IF_ID_FLUSH   (if_id_flush),
        .ID_EX_FLUSH   (id_ex_flush),
        .STATE         (state),
        .STALL_COUNT   (stall_count)
    );

    pc_control_unit #(.CNT_W(4)) dut4 (
        .CLK           (clk),
        .RESET         (rst_n),
        .IMEM_BUSY     (imem4),
        .DMEM_BUSY     (1'b0),
        .LOAD_USE      (1'b0),
        .BRANCH_TAKEN  (1'b0),
        .BRANCH_OFFSET (32'h0),
        .BUSY_WAIT     (busy4),
        .CON_BRANCH    (con4),
        .BRANCH_PC     (bpc4),
        .PC_DEC        (pcdec4),
        .IF_ID_FLUSH   (ifid4),
        .ID_EX_FLUSH   (idex4),
        .STATE         (state4),
        .STALL_COUNT   (stall4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic cb,
                              input logic pd, input logic ifid, input logic idex);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".con_branch"}, 32'(con_branch), 32'(cb));
        check({tag, ".pc_dec"}, 32'(pc_dec), 32'(pd));
        check({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(ifid));
        check({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'(idex));
    endtask

    initial begin
        rst_n         = 1'b0;
        imem_busy     = 1'b0;
        dmem_busy     = 1'b0;
        load_use      = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 32'h0;
        imem4         = 1'b0;

        // Reset state; busy_wait still follows its inputs while counter stays 0
        tick();
        tick();
        imem_busy = 1'b1;
        tick();
        check("rst_busy_wait", 32'(busy_wait), 32'h1);
        check("rst_stall", 32'(stall_count), 32'h0);
        imem_busy = 1'b0;
        #1;
        check("rst_busy_wait_low", 32'(busy_wait), 32'h0);
        check_outs("rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_branch_pc", branch_pc, 32'h0);

        rst_n = 1'b1;
        tick();
        check_outs("idle_to_run", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Taken branch, offset 0x10
        branch_taken  = 1'b1;
        branch_offset = 32'h10;
        tick();
        branch_taken = 1'b0;
        check_outs("br_e0", 2'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        check("br_e0_pc", branch_pc, 32'h10);
        // events during REDIRECT are ignored
        branch_taken  = 1'b1;
        load_use      = 1'b1;
        branch_offset = 32'h44;
        tick();
        branch_taken = 1'b0;
        load_use     = 1'b0;
        check_outs("br_e1", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        check("br_e1_pc", branch_pc, 32'h10);
        tick();
        check_outs("br_e2", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("br_e2_pc_hold", branch_pc, 32'h10);
        check("br_stall", 32'(stall_count), 32'h0);

        // Load-use bubble
        load_use = 1'b1;
        tick();
        load_use = 1'b0;
        check_outs("lu_e0", 2'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        check("lu_e0_stall", 32'(stall_count), 32'h0);
        tick();
        check_outs("lu_e1", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_e1_stall", 32'(stall_count), 32'h1);

        // Branch and load-use together: branch wins
        branch_taken  = 1'b1;
        load_use      = 1'b1;
        branch_offset = 32'h20;
        tick();
        branch_taken = 1'b0;
        load_use     = 1'b0;
        check_outs("both_e0", 2'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        check("both_pc", branch_pc, 32'h20);
        tick();
        tick();
        check_outs("both_e2", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("both_stall", 32'(stall_count), 32'h1);

        // Fresh reset, then 5 busy cycles with a branch parked in cycle 2
        rst_n = 1'b0;
        #1;
        check("rst2_stall", 32'(stall_count), 32'h0);
        check("rst2_pc", branch_pc, 32'h0);
        rst_n = 1'b1;
        tick();
        dmem_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) begin
                branch_taken  = 1'b1;
                branch_offset = 32'hFFFF_FFF8;
            end
            tick();
            branch_taken  = 1'b0;
            branch_offset = 32'h0;
            check_outs($sformatf("busy_c%0d", i), 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("busy_pc_hold", branch_pc, 32'h0);
        dmem_busy = 1'b0;
        tick();
        check_outs("pend_issue", 2'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        check("pend_pc", branch_pc, 32'hFFFF_FFF8);
        check("pend_stall", 32'(stall_count), 32'h5);

        // Reset mid-REDIRECT: outputs clear immediately, nothing after release
        tick();
        check_outs("redir_mid", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outs("rst_mid", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_pc", branch_pc, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check_outs("post_rst_e0", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("post_rst_e1", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // CNT_W=4 saturation over 20 busy cycles
        imem4 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_c14", 32'(stall4), 32'd14);
            if (i == 15) check("sat_c15", 32'(stall4), 32'd15);
        end
        check("sat_c20", 32'(stall4), 32'd15);
        imem4 = 1'b0;
        tick();
        tick();
        check("sat_hold", 32'(stall4), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
